// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// expected truth tables for the two-input gate cells.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Bit i is the expected gate output for input vector i (MSB of the vector = input A).
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/status bundle of the truth-table sweeper: the controller side is the
// master, the sweeper itself is the slave.
interface truth_table_sweeper_if #(
    parameter int N_IN = 2
);

    logic            start;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            err_valid;
    logic [N_IN-1:0] first_err_idx;

    modport master (
        output start,
        input  busy, done, pass, err_count, err_valid, first_err_idx
    );

    modport slave (
        input  start,
        output busy, done, pass, err_count, err_valid, first_err_idx
    );

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-window counter: counts enabled cycles from zero and flags the last
// cycle of the window (cnt == SETTLE-1).
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = (cnt == W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector to a gate cell in ascending order, holds it for a
// settle window, then compares the sampled output against the expected table.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = (2**N_IN)'(TT_NOR)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    truth_table_sweeper_if.slave  ctl,
    output logic [N_IN-1:0]       stim_o,
    input  logic                  dut_y_i
);

    // One extra bit so the last-vector compare never wraps to zero.
    localparam logic [N_IN:0] LAST_VEC = (N_IN + 1)'(2**N_IN - 1);

    sweep_state_t    state;
    sweep_state_t    state_next;
    logic [N_IN:0]   vec;
    logic [N_IN:0]   err_count;
    logic            err_valid;
    logic [N_IN-1:0] first_err_idx;
    logic            pass;
    logic            settle_tc;
    logic            timer_clear;
    logic            timer_en;
    logic            last_vec;
    logic            mismatch;
    logic            busy;
    logic            done;
    logic [N_IN-1:0] stim;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .enable (timer_en),
        .tc     (settle_tc)
    );

    assign last_vec = (vec == LAST_VEC);
    assign mismatch = (dut_y_i != EXPECT[vec[N_IN-1:0]]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stim        = '0;
        busy        = 1'b1;
        done        = 1'b0;
        timer_clear = 1'b1;
        timer_en    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (ctl.start) begin
                    state_next = APPLY;
                end
            end
            APPLY: begin
                stim        = vec[N_IN-1:0];
                timer_clear = 1'b0;
                timer_en    = 1'b1;
                if (settle_tc) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                stim       = vec[N_IN-1:0];
                state_next = last_vec ? DONE : APPLY;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Results are cleared only when a sweep is accepted, so they stay readable after DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec           <= '0;
            err_count     <= '0;
            err_valid     <= 1'b0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctl.start) begin
                        vec           <= '0;
                        err_count     <= '0;
                        err_valid     <= 1'b0;
                        first_err_idx <= '0;
                        pass          <= 1'b0;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_count + (N_IN + 1)'(1);
                        if (!err_valid) begin
                            first_err_idx <= vec[N_IN-1:0];
                            err_valid     <= 1'b1;
                        end
                    end
                    if (!last_vec) begin
                        vec <= vec + (N_IN + 1)'(1);
                    end
                end
                DONE: begin
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

    assign stim_o            = stim;
    assign ctl.busy          = busy;
    assign ctl.done          = done;
    assign ctl.pass          = pass;
    assign ctl.err_count     = err_count;
    assign ctl.err_valid     = err_valid;
    assign ctl.first_err_idx = first_err_idx;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: 2-input sweeps against several gate
// models plus a 3-input NOR sweep with a one-cycle settle window.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] stim2;
    logic       y2;
    logic [2:0] stim3;
    logic       y3;
    int         gate_mode;
    int         checkCount;
    int         errorCount;

    truth_table_sweeper_if #(.N_IN(2)) if2 ();
    truth_table_sweeper_if #(.N_IN(3)) if3 ();

    truth_table_sweeper #(
        .N_IN   (2),
        .SETTLE (2),
        .EXPECT (TT_NOR)
    ) dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (if2.slave),
        .stim_o  (stim2),
        .dut_y_i (y2)
    );

    truth_table_sweeper #(
        .N_IN   (3),
        .SETTLE (1),
        .EXPECT (8'b0000_0001)
    ) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (if3.slave),
        .stim_o  (stim3),
        .dut_y_i (y3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate under test for the 2-input sweeper: 0 NOR, 1 OR, 2 tied low, 3 tied high.
    always_comb begin
        case (gate_mode)
            0:       y2 = ~|stim2;
            1:       y2 = |stim2;
            2:       y2 = 1'b0;
            default: y2 = 1'b1;
        endcase
    end

    assign y3 = ~|stim3;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Runs one 2-input sweep; start is accepted at the first rising edge and
    // done must appear in the cycle after the 12th following edge.
    task automatic applyStimulus(input string name, input int gate, input bit repulse,
                                 input int exp_err, input int exp_valid,
                                 input int exp_idx, input int exp_pass);
        @(negedge clk);
        gate_mode = gate;
        if2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            checkOutput({name, "/stim"}, 32'(stim2), 32'(j / 3));
            checkOutput({name, "/busy"}, 32'(if2.busy), 32'd1);
            if (j != 11) begin
                checkOutput({name, "/done_early"}, 32'(if2.done), 32'd0);
            end
            if2.start = (repulse && j == 5);
            @(negedge clk);
        end
        checkOutput({name, "/done"}, 32'(if2.done), 32'd1);
        checkOutput({name, "/stim_done"}, 32'(stim2), 32'd0);
        @(negedge clk);
        checkOutput({name, "/done_pulse"}, 32'(if2.done), 32'd0);
        checkOutput({name, "/busy_idle"}, 32'(if2.busy), 32'd0);
        checkOutput({name, "/err_count"}, 32'(if2.err_count), 32'(exp_err));
        checkOutput({name, "/err_valid"}, 32'(if2.err_valid), 32'(exp_valid));
        checkOutput({name, "/first_err_idx"}, 32'(if2.first_err_idx), 32'(exp_idx));
        checkOutput({name, "/pass"}, 32'(if2.pass), 32'(exp_pass));
        repeat (3) @(negedge clk);
        checkOutput({name, "/pass_hold"}, 32'(if2.pass), 32'(exp_pass));
        checkOutput({name, "/err_hold"}, 32'(if2.err_count), 32'(exp_err));
    endtask

    initial begin
        bit sawDone;
        checkCount = 0;
        errorCount = 0;
        gate_mode  = 0;
        rst_n      = 1'b0;
        if2.start  = 1'b0;
        if3.start  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset/busy", 32'(if2.busy), 32'd0);
        checkOutput("reset/done", 32'(if2.done), 32'd0);
        checkOutput("reset/pass", 32'(if2.pass), 32'd0);
        checkOutput("reset/err_count", 32'(if2.err_count), 32'd0);
        checkOutput("reset/stim", 32'(stim2), 32'd0);
        checkOutput("reset/busy3", 32'(if3.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] NOR loopback sweep");
        applyStimulus("nor", 0, 1'b0, 0, 0, 0, 1);

        $display("[TB] OR gate against NOR table");
        applyStimulus("or", 1, 1'b0, 4, 1, 0, 0);

        $display("[TB] output tied low against NOR table");
        applyStimulus("tie0", 2, 1'b0, 1, 1, 0, 0);

        $display("[TB] output tied high against NOR table");
        applyStimulus("tie1", 3, 1'b0, 3, 1, 1, 0);

        $display("[TB] start re-pulsed mid-sweep");
        applyStimulus("repulse", 0, 1'b1, 0, 0, 0, 1);

        $display("[TB] reset in the middle of a sweep");
        @(negedge clk);
        gate_mode = 3;
        if2.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if2.start = 1'b0;
        for (int j = 0; j < 6; j++) begin
            checkOutput("abort/stim", 32'(stim2), 32'(j / 3));
            @(negedge clk);
        end
        checkOutput("abort/err_before", 32'(if2.err_count), 32'd1);
        checkOutput("abort/idx_before", 32'(if2.first_err_idx), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort/busy", 32'(if2.busy), 32'd0);
        checkOutput("abort/stim_idle", 32'(stim2), 32'd0);
        checkOutput("abort/err_count", 32'(if2.err_count), 32'd0);
        checkOutput("abort/err_valid", 32'(if2.err_valid), 32'd0);
        checkOutput("abort/first_err_idx", 32'(if2.first_err_idx), 32'd0);
        sawDone = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (if2.done || if2.busy) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("abort/no_done", 32'(sawDone), 32'd0);
        applyStimulus("after_abort", 0, 1'b0, 0, 0, 0, 1);

        $display("[TB] 3-input NOR sweep, settle of one cycle");
        @(negedge clk);
        if3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if3.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            checkOutput("nor3/stim", 32'(stim3), 32'(j / 2));
            checkOutput("nor3/done_early", 32'(if3.done), 32'd0);
            @(negedge clk);
        end
        checkOutput("nor3/done", 32'(if3.done), 32'd1);
        @(negedge clk);
        checkOutput("nor3/pass", 32'(if3.pass), 32'd1);
        checkOutput("nor3/err_count", 32'(if3.err_count), 32'd0);
        checkOutput("nor3/busy_idle", 32'(if3.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
